// File: rtl/add4_resp_checker_if.sv
// Operand/result bundle shared by the adder stimulus side and the response checker.
// Latency: none, this is a plain wire bundle.
// Backpressure: none. The checker observes the bundle and never stalls the driver.
interface add4_resp_checker_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;

  // The stimulus side drives the operands and the adder result.
  modport master (output in_valid, a, b, y);
  // The checker only observes the bundle.
  modport slave  (input  in_valid, a, b, y);
endinterface

// File: rtl/add4_resp_checker.sv
// Hardware scoreboard for the 4-bit adder. It counts pass/fail, captures the first mismatch, and flags done after N_CHECKS samples.
// Latency: a sample taken at edge k updates the counters and err at edge k+1. done rises at the edge after the final sample.
// Backpressure: none. Every in_valid cycle in RUN is accepted, so the checker sustains one transaction per cycle.
module add4_resp_checker #(
  parameter int WIDTH    = 4,
  parameter int N_CHECKS = 8,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  add4_resp_checker_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err,
  output logic [WIDTH-1:0]     err_a,
  output logic [WIDTH-1:0]     err_b,
  output logic [WIDTH-1:0]     err_y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  // The sample count is compared before it increments, so the last sample is N_CHECKS-1.
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N_CHECKS - 1);

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_y;
  logic [WIDTH-1:0] s1_exp;

  // Expected sum. The carry is dropped because y is only WIDTH bits wide.
  assign s1_exp = s1_a + s1_b;

  // Control FSM, stage-1 sample registers and stage-2 compare/scoreboard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err        <= 1'b0;
      err_a      <= '0;
      err_b      <= '0;
      err_y      <= '0;
      sample_cnt <= '0;
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_y       <= '0;
    end else begin
      // Stage 2 retires whatever stage 1 holds, regardless of state.
      // Stage 1 is always empty in IDLE and DONE, so this never races the clear on start.
      if (s1_vld) begin
        if (s1_y == s1_exp) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
          if (!err) begin
            err   <= 1'b1;
            err_a <= s1_a;
            err_b <= s1_b;
            err_y <= s1_y;
          end
        end
      end

      s1_vld <= 1'b0;

      case (state)
        IDLE, DONE: begin
          // A fresh run starts from a fully cleared scoreboard.
          // in_valid in the start cycle is deliberately not sampled.
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            err        <= 1'b0;
            err_a      <= '0;
            err_b      <= '0;
            err_y      <= '0;
            sample_cnt <= '0;
          end
        end
        RUN: begin
          // start is ignored here so that a run cannot be restarted midway.
          if (bus.in_valid) begin
            s1_vld     <= 1'b1;
            s1_a       <= bus.a;
            s1_b       <= bus.b;
            s1_y       <= bus.y;
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_SAMPLE) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final sample retires on this edge, so the counters are final when done rises.
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
